// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_mp_pkg;

  localparam int REGFILE_DATA_W = 64;
  localparam int REGFILE_DEPTH  = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Address width for a given depth, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_wsel.sv
// Combinational write-port priority resolver. For every lookup address it
// reports whether an enabled in-range write hits it and which data wins
// (highest-index port). Also flags two or more valid ports on one address.
module regfile_mp_wsel
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int DEPTH  = REGFILE_DEPTH,
  parameter int NWR    = 2,
  parameter int NLOOK  = 1,
  parameter int AW     = clog2_min1(REGFILE_DEPTH)
) (
  input  logic [NWR-1:0]          we,
  input  logic [NWR*AW-1:0]       waddr,
  input  logic [NWR*DATA_W-1:0]   wdata,
  input  logic [NLOOK*AW-1:0]     look_addr,
  output logic [NLOOK-1:0]        hit,
  output logic [NLOOK*DATA_W-1:0] hit_data,
  output logic                    conflict
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [NWR-1:0] valid_s;

  // A write port only counts when enabled and addressing a real entry
  always_comb begin
    valid_s = {NWR{1'b0}};
    for (int i = 0; i < NWR; i++) begin
      valid_s[i] = we[i] & ({1'b0, waddr[i*AW +: AW]} < DEPTH_W);
    end
  end

  // Per-lookup resolve: scanning ports upward lets the highest index win
  always_comb begin
    logic match_v;
    match_v  = 1'b0;
    hit      = {NLOOK{1'b0}};
    hit_data = {(NLOOK*DATA_W){1'b0}};
    for (int l = 0; l < NLOOK; l++) begin
      for (int i = 0; i < NWR; i++) begin
        match_v = valid_s[i] & (waddr[i*AW +: AW] == look_addr[l*AW +: AW]);
        hit[l]  = hit[l] | match_v;
        hit_data[l*DATA_W +: DATA_W] = match_v ? wdata[i*DATA_W +: DATA_W]
                                                : hit_data[l*DATA_W +: DATA_W];
      end
    end
  end

  // Conflict whenever any pair of valid ports shares an address
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        conflict = conflict | (valid_s[i] & valid_s[j] &
                               (waddr[i*AW +: AW] == waddr[j*AW +: AW]));
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a post-reset clear sweep,
// deterministic write priority, optional write-to-read bypass and a
// registered write-conflict flag. The array has no per-entry reset.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int                DATA_W   = REGFILE_DATA_W,
  parameter int                DEPTH    = REGFILE_DEPTH,
  parameter int                NWR      = 2,
  parameter int                NRD      = 1,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}},
  localparam int               AW       = clog2_min1(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NWR-1:0]          we,
  input  logic [NWR*AW-1:0]       waddr,
  input  logic [NWR*DATA_W-1:0]   wdata,
  input  logic [NRD*AW-1:0]       raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  output logic                    ready,
  output logic                    wr_conflict
);

  // Lookups 0..DEPTH-1 drive the array update, DEPTH.. serve read bypass
  localparam int              NLOOK    = DEPTH + NRD;
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]     DEPTH_W  = DEPTH[AW:0];

  state_t                    state_r;
  logic [AW-1:0]             clr_ptr_r;
  logic                      ready_r;
  logic                      wr_conflict_r;
  logic [DATA_W-1:0]         mem_r [DEPTH];

  logic [NLOOK*AW-1:0]       look_addr_s;
  logic [NLOOK-1:0]          hit_s;
  logic [NLOOK*DATA_W-1:0]   hit_data_s;
  logic                      conflict_s;

  // Build lookup list: every entry index, then every read address
  always_comb begin
    look_addr_s = {(NLOOK*AW){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      look_addr_s[k*AW +: AW] = AW'(k);
    end
    for (int j = 0; j < NRD; j++) begin
      look_addr_s[(DEPTH+j)*AW +: AW] = raddr[j*AW +: AW];
    end
  end

  regfile_mp_wsel #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NWR    (NWR),
    .NLOOK  (NLOOK),
    .AW     (AW)
  ) u_wsel (
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .look_addr (look_addr_s),
    .hit       (hit_s),
    .hit_data  (hit_data_s),
    .conflict  (conflict_s)
  );

  // Clear sequencer, ready and conflict flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= CLEAR;
      clr_ptr_r     <= {AW{1'b0}};
      ready_r       <= 1'b0;
      wr_conflict_r <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          wr_conflict_r <= 1'b0;
          if (clr_ptr_r == LAST_PTR) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            clr_ptr_r <= clr_ptr_r + AW'(1'b1);
          end
        end
        RUN: begin
          wr_conflict_r <= conflict_s;
        end
        default: begin
          state_r       <= CLEAR;
          clr_ptr_r     <= {AW{1'b0}};
          ready_r       <= 1'b0;
          wr_conflict_r <= 1'b0;
        end
      endcase
    end
  end

  // Array storage: sweep writes INIT_VAL, RUN applies the resolved writes
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == CLEAR)) begin
      mem_r[clr_ptr_r] <= INIT_VAL;
    end else if (rst_n && (state_r == RUN)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (hit_s[k]) begin
          mem_r[k] <= hit_data_s[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read muxes: INIT_VAL while clearing, then bypass, stored value or zero
  always_comb begin
    logic [AW-1:0] ra_v;
    ra_v  = {AW{1'b0}};
    rdata = {(NRD*DATA_W){1'b0}};
    for (int j = 0; j < NRD; j++) begin
      ra_v = raddr[j*AW +: AW];
      if (state_r != RUN) begin
        rdata[j*DATA_W +: DATA_W] = INIT_VAL;
      end else if ((BYPASS != 0) && hit_s[DEPTH+j]) begin
        rdata[j*DATA_W +: DATA_W] = hit_data_s[(DEPTH+j)*DATA_W +: DATA_W];
      end else if ({1'b0, ra_v} < DEPTH_W) begin
        rdata[j*DATA_W +: DATA_W] = mem_r[ra_v];
      end else begin
        rdata[j*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  assign ready       = ready_r;
  assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Two instances share the stimulus:
// u_a (DEPTH 32, bypass, INIT 0) and u_b (DEPTH 20, no bypass, INIT_B).
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam logic [63:0] INIT_B = 64'h5A5A_5A5A_0000_005A;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        we;
  logic [2*AW-1:0]   waddr;
  logic [2*DW-1:0]   wdata;
  logic [2*AW-1:0]   raddr;
  logic [2*DW-1:0]   rdata_a, rdata_b;
  logic              ready_a, ready_b, conf_a, conf_b;

  logic [63:0] mdl_a [32];
  logic [63:0] mdl_b [20];
  logic [63:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(64), .DEPTH(32), .NWR(2), .NRD(2), .BYPASS(1),
               .INIT_VAL(64'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .ready(ready_a), .wr_conflict(conf_a));

  regfile_mp #(.DATA_W(64), .DEPTH(20), .NWR(2), .NRD(2), .BYPASS(0),
               .INIT_VAL(INIT_B)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .ready(ready_b), .wr_conflict(conf_b));

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference write behaviour: in-range only, higher port applied last wins
  task automatic model_write();
    int a;
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        a = int'(waddr[i*AW +: AW]);
        if (a < 32) mdl_a[a] = wdata[i*DW +: DW];
        if (a < 20) mdl_b[a] = wdata[i*DW +: DW];
      end
    end
  endtask

  function automatic logic exp_conf(input int depth);
    return we[0] && we[1] && (waddr[AW-1:0] == waddr[2*AW-1:AW]) &&
           (int'(waddr[AW-1:0]) < depth);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_a[i] = 64'h0;
    for (int i = 0; i < 20; i++) mdl_b[i] = INIT_B;
  endtask

  task automatic sweep_ready(input string tag);
    for (int e = 1; e <= 32; e++) begin
      if (e > 10) we = 2'b00;
      step();
      push(64'(e >= 32)); chk({tag, "_rdy_a"}, 64'(ready_a));
      push(64'(e >= 20)); chk({tag, "_rdy_b"}, 64'(ready_b));
      if (e == 3) begin
        push(64'h0);  chk({tag, "_clr_rd_a"}, rdata_a[63:0]);
        push(INIT_B); chk({tag, "_clr_rd_b"}, rdata_b[63:0]);
        push(64'h0);  chk({tag, "_clr_conf_a"}, 64'(conf_a));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 2'b11;
    waddr = {5'd5, 5'd0};
    wdata = {64'hDEAD_0001, 64'hDEAD_0000};
    raddr = {5'd0, 5'd0};

    // Reset held two cycles
    step(); step();
    push(64'h0); chk("rst_rdy_a", 64'(ready_a));
    push(64'h0); chk("rst_rdy_b", 64'(ready_b));
    push(64'h0); chk("rst_conf_a", 64'(conf_a));
    push(64'h0); chk("rst_conf_b", 64'(conf_b));

    // Clear sweep with writes requested during the first 10 edges
    rst_n = 1'b1;
    model_clear();
    sweep_ready("clr");

    // Every entry reads its clear value; B beyond DEPTH reads 0
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      push(mdl_a[i]);                  chk("init_rd_a", rdata_a[63:0]);
      push(i < 20 ? mdl_b[i] : 64'h0); chk("init_rd_b", rdata_b[127:64]);
    end

    // Priority/conflict: both ports on address 5
    we = 2'b11; waddr = {5'd5, 5'd5};
    wdata = {64'hBBBB, 64'hAAAA}; raddr = {5'd5, 5'd5};
    #1;
    push(64'hBBBB);  chk("prio_byp_a", rdata_a[63:0]);
    push(mdl_b[5]);  chk("prio_old_b", rdata_b[63:0]);
    push(64'(exp_conf(32))); push(64'(exp_conf(20)));
    model_write();
    step(); we = 2'b00; #1;
    chk("prio_conf_a", 64'(conf_a));
    chk("prio_conf_b", 64'(conf_b));
    push(64'hBBBB); chk("prio_rd_a", rdata_a[63:0]);
    push(64'hBBBB); chk("prio_rd_b", rdata_b[63:0]);
    step();
    push(64'h0); chk("prio_conf_a_drop", 64'(conf_a));
    push(64'h0); chk("prio_conf_b_drop", 64'(conf_b));

    // Bypass versus read-first on address 7
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {64'h0, 64'h1234};
    raddr = {5'd0, 5'd7};
    #1;
    push(64'h1234);  chk("byp_a", rdata_a[63:0]);
    push(mdl_b[7]);  chk("nobyp_b_old", rdata_b[63:0]);
    model_write();
    step(); we = 2'b00; #1;
    push(mdl_b[7]);  chk("nobyp_b_new", rdata_b[63:0]);
    push(64'h0);     chk("byp_conf_a", 64'(conf_a));

    // Independent ports, two read ports
    we = 2'b11; waddr = {5'd2, 5'd1}; wdata = {64'h22, 64'h11};
    push(64'(exp_conf(32)));
    model_write();
    step(); we = 2'b00; raddr = {5'd2, 5'd1}; #1;
    chk("ind_conf_a", 64'(conf_a));
    push(64'h11); chk("ind_a_p0", rdata_a[63:0]);
    push(64'h22); chk("ind_a_p1", rdata_a[127:64]);
    push(64'h11); chk("ind_b_p0", rdata_b[63:0]);
    push(64'h22); chk("ind_b_p1", rdata_b[127:64]);

    // Address 25: in range for A, out of range for B
    we = 2'b11; waddr = {5'd25, 5'd25}; wdata = {64'hFF, 64'hEE};
    raddr = {5'd0, 5'd25};
    #1;
    push(64'hFF); chk("oor_byp_a", rdata_a[63:0]);
    push(64'h0);  chk("oor_rd_b", rdata_b[63:0]);
    push(64'(exp_conf(32))); push(64'(exp_conf(20)));
    model_write();
    step(); we = 2'b00; #1;
    chk("oor_conf_a", 64'(conf_a));
    chk("oor_conf_b", 64'(conf_b));
    push(64'hFF); chk("oor_stored_a", rdata_a[63:0]);
    push(64'h0);  chk("oor_after_b", rdata_b[63:0]);
    for (int i = 0; i < 20; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      push(mdl_b[i]); chk("oor_intact_b", rdata_b[63:0]);
    end

    // Reset in the middle of a later sweep
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {64'h0, 64'h55};
    model_write();
    step(); we = 2'b00; raddr = {5'd0, 5'd3}; #1;
    push(64'h55); chk("mid_pre_a", rdata_a[63:0]);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int e = 0; e < 10; e++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    push(64'h0); chk("mid_rst_rdy_a", 64'(ready_a));
    model_clear();
    sweep_ready("mid");
    raddr = {5'd3, 5'd3}; #1;
    push(mdl_a[3]); chk("mid_rd3_a", rdata_a[63:0]);
    push(mdl_b[3]); chk("mid_rd3_b", rdata_b[63:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the team's fixed two-write/one-read 64x32 register file.
- Configurable depth, width, write-port count and read-port count; deterministic write-port priority.
- Optional same-cycle write-to-read bypass and a registered write-conflict flag.
- Hardware clear sequencer after reset so the array maps to distributed RAM without a per-entry reset. Sits beside the execution datapath as the architectural register store.

Parameters:
- DATA_W, 64, entry width in bits
- DEPTH, 32, number of entries (need not be a power of two; minimum 2)
- NWR, 2, number of write ports (1..4)
- NRD, 1, number of read ports (1..4)
- BYPASS, 1, 1 = read returns same-cycle winning write data; 0 = read returns stored value
- INIT_VAL, 0, value written to every entry by the clear sequencer

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- we  input  NWR  per-port write enable
- waddr  input  NWR*AW  packed write addresses, port i at [i*AW +: AW], AW = $clog2(DEPTH)
- wdata  input  NWR*DATA_W  packed write data, port i at [i*DATA_W +: DATA_W]
- raddr  input  NRD*AW  packed read addresses
- rdata  output  NRD*DATA_W  packed read data, combinational
- ready  output  1  high once clear sequence completes
- wr_conflict  output  1  registered pulse: two or more enabled write ports hit the same address last cycle

Behaviour:
- Reset: one clock; rst_n low sampled at a posedge forces the following:
  - state <= CLEAR, clr_ptr <= 0, ready <= 0, wr_conflict <= 0.
  - Array contents are not touched by reset itself.
- States:
  - CLEAR: on each posedge with rst_n high, entry[clr_ptr] <= INIT_VAL and clr_ptr++.
  - CLEAR -> RUN: at the edge that clears entry DEPTH-1, the block moves to RUN and ready <= 1.
  - ready therefore rises exactly DEPTH edges after the first edge with rst_n high.
- CLEAR rules:
  - All we ignored.
  - rdata forced to INIT_VAL on every port.
  - wr_conflict held 0.
- Reset mid-CLEAR or mid-RUN: returns to CLEAR with clr_ptr = 0 and restarts the full sweep; no partial state retained.
- RUN, writes:
  - On posedge, each port i with we[i]=1 and waddr_i < DEPTH writes wdata_i.
  - Several ports on the same address: highest-index port wins (port NWR-1 over port 0); losing writes discarded.
- RUN, out-of-range addresses:
  - Writes to waddr >= DEPTH are dropped silently.
  - Reads with raddr >= DEPTH return 0.
- RUN, reads: rdata_j = entry[raddr_j], zero-latency combinational.
- Bypass:
  - BYPASS=1: if any enabled in-range write targets raddr_j this cycle, rdata_j = the winning wdata (write-first).
  - BYPASS=0: rdata_j = pre-edge stored value (read-first); the new value is visible the cycle after the write.
- wr_conflict:
  - Registered; set to 1 for exactly one cycle after any cycle where at least two enabled in-range write ports share an address.
  - Otherwise 0. Identical data still counts as a conflict.
- Width rules: no arithmetic on data; clr_ptr is AW bits and never wraps past DEPTH-1 (it is held in RUN).

Decomposition:
- Shared package regfile_mp_pkg contains:
  - State enum state_t {CLEAR, RUN}.
  - Helper function clog2_min1 (returns at least 1 for AW).
  - Default constants REGFILE_DATA_W=64 and REGFILE_DEPTH=32.
- One sub-module, regfile_mp_wsel: purely combinational write-port priority resolver. It takes we/waddr/wdata and produces, per address lookup, the winning hit/data plus the conflict detect. It is used for both array update and bypass.
- Array, clear sequencer and read muxes stay in regfile_mp.

Test Plan:
- Reset then idle (DEPTH=32, INIT_VAL=0): rst_n low 2 cycles, then high → ready=0 for 31 edges, ready=1 after 32nd edge; all 32 entries read 0; we asserted during CLEAR has no effect.
- Priority/conflict (NWR=2): RUN, we=2'b11, waddr0=waddr1=5, wdata0=64'hAAAA, wdata1=64'hBBBB → next cycle entry5 reads 64'hBBBB and wr_conflict=1 for exactly one cycle, then 0.
- Bypass (BYPASS=1): write port0 addr 7 data 64'h1234 while raddr0=7 → rdata0=64'h1234 same cycle. With BYPASS=0, same stimulus → rdata0 shows old value, then 64'h1234 next cycle.
- Independent ports (NWR=2, NRD=2): port0 writes addr 1=64'h11, port1 writes addr 2=64'h22 same edge → both stored; wr_conflict=0; reads of 1 and 2 on two read ports return 64'h11/64'h22.
- Non-power-of-two depth (DEPTH=20): write addr 25 data 64'hFF → no entry changes; raddr=25 returns 0; ready rises after 20 edges.
- Reset mid-operation: write addr 3=64'h55, assert rst_n for 1 cycle at clr_ptr=10 of a later sweep → sweep restarts, ready low for full DEPTH edges, entry 3 reads INIT_VAL after ready.
